instr_decode_queue: RTL and testbench

- Parametrised multi-lane instruction queue with a decode stage, sitting between fetch and the issue/register-read stage.
- Accepts up to IN_W raw 32-bit RV64IM instructions per cycle, each with its PC.
- Buffers them in a circular queue of DEPTH entries.
- Presents up to OUT_W decoded instructions (decoded_instr_t plus pc) per cycle to the consumer.
- Generalises the single-lane decode path to a superscalar front end with backpressure and flush.

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/instr_decoder.sv | 212 +++++++++++++++++++++
 rtl/instr_decode_queue.sv | 137 +++++++++++++
 tb/tb_instr_decode_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode types and constants for the instruction queue and decoder.
package decode_pkg;

  localparam int unsigned DQ_DEPTH = 8;
  localparam int unsigned DQ_IN_W  = 2;
  localparam int unsigned DQ_OUT_W = 2;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [6:0] {
    OP_ILLEGAL,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
    OP_FENCE, OP_ECALL, OP_EBREAK,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
  } op_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
  } ctl_t;

  typedef struct packed {
    op_e         op;
    ctl_t        ctl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] csr_addr;
    logic [63:0] imm;
  } decoded_instr_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    decoded_instr_t instr;
    logic [63:0]    pc;
    logic           illegal;
  } dq_out_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV64IM decoder: one raw word in, decoded fields plus illegal flag out.
// Illegal encodings report OP_ILLEGAL with all control bits cleared.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t decoded,
  output logic           illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh;
  logic        bad;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign f6     = instr[31:26];
  assign imm_i  = {{52{instr[31]}}, instr[31:20]};
  assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_z  = {59'b0, instr[19:15]};
  assign imm_sh = {58'b0, instr[25:20]};

  // Decode opcode/funct fields into operation, controls and immediate
  always_comb begin
    decoded          = '0;
    decoded.rd       = instr[11:7];
    decoded.rs1      = instr[19:15];
    decoded.rs2      = instr[24:20];
    decoded.csr_addr = instr[31:20];
    bad              = 1'b0;
    case (opc)
      OPC_LUI: begin
        decoded.op = OP_LUI; decoded.ctl.regwrite = 1'b1; decoded.imm = imm_u;
      end
      OPC_AUIPC: begin
        decoded.op = OP_AUIPC; decoded.ctl.regwrite = 1'b1; decoded.imm = imm_u;
      end
      OPC_JAL: begin
        decoded.op = OP_JAL; decoded.ctl.regwrite = 1'b1; decoded.ctl.jump = 1'b1;
        decoded.imm = imm_j;
      end
      OPC_JALR: begin
        decoded.op = OP_JALR; decoded.ctl.regwrite = 1'b1; decoded.ctl.jump = 1'b1;
        decoded.imm = imm_i;
        bad = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        decoded.ctl.branch = 1'b1; decoded.imm = imm_b;
        case (f3)
          3'd0: decoded.op = OP_BEQ;
          3'd1: decoded.op = OP_BNE;
          3'd4: decoded.op = OP_BLT;
          3'd5: decoded.op = OP_BGE;
          3'd6: decoded.op = OP_BLTU;
          3'd7: decoded.op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        decoded.ctl.regwrite = 1'b1; decoded.ctl.memread = 1'b1; decoded.imm = imm_i;
        case (f3)
          3'd0: decoded.op = OP_LB;
          3'd1: decoded.op = OP_LH;
          3'd2: decoded.op = OP_LW;
          3'd3: decoded.op = OP_LD;
          3'd4: decoded.op = OP_LBU;
          3'd5: decoded.op = OP_LHU;
          3'd6: decoded.op = OP_LWU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        decoded.ctl.memwrite = 1'b1; decoded.imm = imm_s;
        case (f3)
          3'd0: decoded.op = OP_SB;
          3'd1: decoded.op = OP_SH;
          3'd2: decoded.op = OP_SW;
          3'd3: decoded.op = OP_SD;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        decoded.ctl.regwrite = 1'b1; decoded.imm = imm_i;
        case (f3)
          3'd0: decoded.op = OP_ADDI;
          3'd2: decoded.op = OP_SLTI;
          3'd3: decoded.op = OP_SLTIU;
          3'd4: decoded.op = OP_XORI;
          3'd6: decoded.op = OP_ORI;
          3'd7: decoded.op = OP_ANDI;
          3'd1: begin
            decoded.op = OP_SLLI; decoded.imm = imm_sh; bad = (f6 != 6'b000000);
          end
          default: begin
            decoded.imm = imm_sh;
            if (f6 == 6'b000000)      decoded.op = OP_SRLI;
            else if (f6 == 6'b010000) decoded.op = OP_SRAI;
            else                      bad = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        decoded.ctl.regwrite = 1'b1; decoded.imm = imm_i;
        case (f3)
          3'd0: decoded.op = OP_ADDIW;
          3'd1: begin
            decoded.op = OP_SLLIW; decoded.imm = imm_sh; bad = (f7 != F7_BASE);
          end
          3'd5: begin
            decoded.imm = imm_sh;
            if (f7 == F7_BASE)     decoded.op = OP_SRLIW;
            else if (f7 == F7_ALT) decoded.op = OP_SRAIW;
            else                   bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        decoded.ctl.regwrite = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: decoded.op = OP_ADD;
            3'd1: decoded.op = OP_SLL;
            3'd2: decoded.op = OP_SLT;
            3'd3: decoded.op = OP_SLTU;
            3'd4: decoded.op = OP_XOR;
            3'd5: decoded.op = OP_SRL;
            3'd6: decoded.op = OP_OR;
            default: decoded.op = OP_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      decoded.op = OP_SUB;
          else if (f3 == 3'd5) decoded.op = OP_SRA;
          else                 bad = 1'b1;
        end else if (f7 == F7_MULDIV) begin
          case (f3)
            3'd0: decoded.op = OP_MUL;
            3'd1: decoded.op = OP_MULH;
            3'd2: decoded.op = OP_MULHSU;
            3'd3: decoded.op = OP_MULHU;
            3'd4: decoded.op = OP_DIV;
            3'd5: decoded.op = OP_DIVU;
            3'd6: decoded.op = OP_REM;
            default: decoded.op = OP_REMU;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_32: begin
        decoded.ctl.regwrite = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: decoded.op = OP_ADDW;
            3'd1: decoded.op = OP_SLLW;
            3'd5: decoded.op = OP_SRLW;
            default: bad = 1'b1;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      decoded.op = OP_SUBW;
          else if (f3 == 3'd5) decoded.op = OP_SRAW;
          else                 bad = 1'b1;
        end else if (f7 == F7_MULDIV) begin
          case (f3)
            3'd0: decoded.op = OP_MULW;
            3'd4: decoded.op = OP_DIVW;
            3'd5: decoded.op = OP_DIVUW;
            3'd6: decoded.op = OP_REMW;
            3'd7: decoded.op = OP_REMUW;
            default: bad = 1'b1;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        decoded.op = OP_FENCE;
        bad = (f3 != 3'd0);
      end
      OPC_SYSTEM: begin
        case (f3)
          3'd0: begin
            if (instr == 32'h0000_0073)      decoded.op = OP_ECALL;
            else if (instr == 32'h0010_0073) decoded.op = OP_EBREAK;
            else                             bad = 1'b1;
          end
          3'd1: begin decoded.op = OP_CSRRW;  decoded.ctl.regwrite = 1'b1; end
          3'd2: begin decoded.op = OP_CSRRS;  decoded.ctl.regwrite = 1'b1; end
          3'd3: begin decoded.op = OP_CSRRC;  decoded.ctl.regwrite = 1'b1; end
          3'd5: begin decoded.op = OP_CSRRWI; decoded.ctl.regwrite = 1'b1; decoded.imm = imm_z; end
          3'd6: begin decoded.op = OP_CSRRSI; decoded.ctl.regwrite = 1'b1; decoded.imm = imm_z; end
          3'd7: begin decoded.op = OP_CSRRCI; decoded.ctl.regwrite = 1'b1; decoded.imm = imm_z; end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      decoded.op  = OP_ILLEGAL;
      decoded.ctl = '0;
    end
    illegal = bad;
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Multi-lane circular instruction queue with per-lane decode on the output side.
// Optional same-cycle bypass into an empty queue: define INSTR_QUEUE_BYPASS_EN.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = DQ_DEPTH,
  parameter int unsigned IN_W  = DQ_IN_W,
  parameter int unsigned OUT_W = DQ_OUT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [IN_W-1:0]                  in_valid,
  input  logic [IN_W-1:0][31:0]            in_instr,
  input  logic [IN_W-1:0][63:0]            in_pc,
  output logic                             in_ready,
  output logic [OUT_W-1:0]                 out_valid,
  output decoded_instr_t [OUT_W-1:0]       out_instr,
  output logic [OUT_W-1:0][63:0]           out_pc,
  output logic [OUT_W-1:0]                 out_illegal,
  input  logic [$clog2(OUT_W+1)-1:0]       out_take
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NW = $clog2(IN_W + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [NW-1:0] n_in;
  logic          run;
  logic [CW-1:0] n_acc, take_req, take_cnt, avail, skip, deq;
  logic          bypass;

  assign in_ready = (count <= CW'(DEPTH - IN_W));

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = (count == '0) && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Count the leading contiguous valid lanes starting at lane 0
  always_comb begin
    n_in = '0;
    run  = 1'b1;
    for (int unsigned j = 0; j < IN_W; j++) begin
      run = run & in_valid[j];
      if (run) n_in = n_in + NW'(1);
    end
  end

  // Accepted lane count, clamped take, and the split between bypassed and dequeued entries
  always_comb begin
    n_acc    = (in_ready && !flush) ? CW'(n_in) : '0;
    take_req = CW'(out_take);
    avail    = count;
    if (bypass) avail = (n_acc > CW'(OUT_W)) ? CW'(OUT_W) : n_acc;
    take_cnt = (take_req > avail) ? avail : take_req;
    skip     = bypass ? take_cnt : '0;
    deq      = bypass ? '0 : take_cnt;
  end

  // Storage write: accepted lanes not consumed through the bypass are packed from tail onward
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned j = 0; j < IN_W; j++) begin
        if (CW'(j) >= skip && CW'(j) < n_acc)
          mem[tail + PW'(CW'(j) - skip)] <= '{instr: in_instr[j], pc: in_pc[j]};
      end
    end
  end

  // Pointer and occupancy update; flush shares the reset path
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(n_acc - skip);
      count <= count + n_acc - skip - deq;
    end
  end

  for (genvar i = 0; i < OUT_W; i++) begin : g_lane
    logic [PW-1:0]  rd_idx;
    decoded_instr_t q_dec;
    logic           q_ill;
    dq_out_t        lane;
    logic           lane_v;

    assign rd_idx = head + PW'(i);

    instr_decoder u_dec (
      .instr   (mem[rd_idx].instr),
      .decoded (q_dec),
      .illegal (q_ill)
    );

`ifdef INSTR_QUEUE_BYPASS_EN
    if (i < IN_W) begin : g_byp
      decoded_instr_t b_dec;
      logic           b_ill;

      instr_decoder u_byp_dec (
        .instr   (in_instr[i]),
        .decoded (b_dec),
        .illegal (b_ill)
      );

      assign lane.instr   = bypass ? b_dec : q_dec;
      assign lane.pc      = bypass ? in_pc[i] : mem[rd_idx].pc;
      assign lane.illegal = bypass ? b_ill : q_ill;
      assign lane_v       = bypass ? (n_acc > CW'(i)) : (count > CW'(i));
    end else begin : g_nobyp
      assign lane.instr   = q_dec;
      assign lane.pc      = mem[rd_idx].pc;
      assign lane.illegal = q_ill;
      assign lane_v       = !bypass && (count > CW'(i));
    end
`else
    assign lane.instr   = q_dec;
    assign lane.pc      = mem[rd_idx].pc;
    assign lane.illegal = q_ill;
    assign lane_v       = (count > CW'(i));
`endif

    assign out_valid[i]   = lane_v;
    assign out_instr[i]   = lane.instr;
    assign out_pc[i]      = lane.pc;
    assign out_illegal[i] = lane.illegal;
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue at default parameters (DEPTH=8, IN_W=2, OUT_W=2).
module tb_instr_decode_queue;
  import decode_pkg::*;

`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    logic [63:0] pc;
    op_e         op;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        regwrite;
    logic        illegal;
    logic        chk_rs1;
    logic        chk_rs2;
    logic        chk_imm;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset, flush;
  logic [1:0]            in_valid;
  logic [1:0][31:0]      in_instr;
  logic [1:0][63:0]      in_pc;
  logic                  in_ready;
  logic [1:0]            out_valid;
  decoded_instr_t [1:0]  out_instr;
  logic [1:0][63:0]      out_pc;
  logic [1:0]            out_illegal;
  logic [1:0]            out_take;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  exp_t        sb[$];
  logic [63:0] pc_next = 64'h8000_0000;

  instr_decode_queue #(.DEPTH(8), .IN_W(2), .OUT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .out_take    (out_take)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [11:0] imm, input logic [63:0] pc);
    exp_t e;
    e.word = {imm, rs1, 3'b000, rd, 7'b0010011};
    e.pc = pc; e.op = OP_ADDI; e.imm = {{52{imm[11]}}, imm};
    e.rs1 = rs1; e.rs2 = '0; e.regwrite = 1'b1; e.illegal = 1'b0;
    e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b0; e.chk_imm = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_add(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [63:0] pc);
    exp_t e;
    e.word = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    e.pc = pc; e.op = OP_ADD; e.imm = '0;
    e.rs1 = rs1; e.rs2 = rs2; e.regwrite = 1'b1; e.illegal = 1'b0;
    e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1; e.chk_imm = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [11:0] imm, input logic [63:0] pc);
    exp_t e;
    e.word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    e.pc = pc; e.op = OP_SW; e.imm = {{52{imm[11]}}, imm};
    e.rs1 = rs1; e.rs2 = rs2; e.regwrite = 1'b0; e.illegal = 1'b0;
    e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1; e.chk_imm = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_bad(input logic [63:0] pc);
    exp_t e;
    e.word = 32'hFFFF_FFFF;
    e.pc = pc; e.op = OP_ILLEGAL; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.regwrite = 1'b0; e.illegal = 1'b1;
    e.chk_rs1 = 1'b0; e.chk_rs2 = 1'b0; e.chk_imm = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_rand(input logic [63:0] pc);
    logic [4:0]  a, b, c;
    logic [11:0] im;
    a = 5'($urandom); b = 5'($urandom); c = 5'($urandom); im = 12'($urandom);
    case ($urandom_range(0, 3))
      0:       return mk_addi(a, b, im, pc);
      1:       return mk_add(a, b, c, pc);
      2:       return mk_sw(a, b, im, pc);
      default: return mk_bad(pc);
    endcase
  endfunction

  function automatic exp_t next_entry();
    exp_t e;
    e = mk_rand(pc_next);
    pc_next = pc_next + 64'd4;
    return e;
  endfunction

  function automatic int unsigned lead_ones(input logic [1:0] v);
    return v[0] ? (v[1] ? 2 : 1) : 0;
  endfunction

  // Number of output lanes the consumer may take this cycle
  function automatic int unsigned avail_of(input logic [1:0] v, input logic fl);
    if (BYP && sb.size() == 0 && !fl) return lead_ones(v);
    return (sb.size() < 2) ? sb.size() : 2;
  endfunction

  // One clock of stimulus: drive, compare presented lanes, then update the scoreboard
  task automatic step(input logic [1:0] v, input exp_t a, input exp_t b,
                      input int unsigned take, input logic fl);
    exp_t        lanes[2];
    exp_t        pres[$];
    int unsigned nin;
    logic        rdy, byp;
    logic [1:0]  exp_v;
    exp_t        dropped;
    lanes[0] = a;
    lanes[1] = b;
    nin = lead_ones(v);
    @(negedge clk);
    in_valid = v; in_instr[0] = a.word; in_instr[1] = b.word;
    in_pc[0] = a.pc; in_pc[1] = b.pc; out_take = 2'(take); flush = fl;
    byp = BYP && (sb.size() == 0) && !fl;
    if (byp) begin
      for (int unsigned i = 0; i < nin; i++) pres.push_back(lanes[i]);
    end else begin
      for (int unsigned i = 0; i < sb.size() && i < 2; i++) pres.push_back(sb[i]);
    end
    rdy = (sb.size() <= 6);
    exp_v = '0;
    for (int unsigned i = 0; i < pres.size(); i++) exp_v[i] = 1'b1;
    #1;
    assert (take <= pres.size())
      else $error("protocol: out_take %0d exceeds %0d valid lanes", take, pres.size());
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("out_valid", 64'(out_valid), 64'(exp_v));
    for (int unsigned i = 0; i < pres.size(); i++) begin
      check($sformatf("pc[%0d]", i), out_pc[i], pres[i].pc);
      check($sformatf("op[%0d]", i), 64'(out_instr[i].op), 64'(pres[i].op));
      check($sformatf("illegal[%0d]", i), 64'(out_illegal[i]), 64'(pres[i].illegal));
      check($sformatf("regwrite[%0d]", i), 64'(out_instr[i].ctl.regwrite), 64'(pres[i].regwrite));
      if (pres[i].illegal)
        check($sformatf("ctl[%0d]", i), 64'(out_instr[i].ctl), 64'd0);
      if (pres[i].chk_rs1)
        check($sformatf("rs1[%0d]", i), 64'(out_instr[i].rs1), 64'(pres[i].rs1));
      if (pres[i].chk_rs2)
        check($sformatf("rs2[%0d]", i), 64'(out_instr[i].rs2), 64'(pres[i].rs2));
      if (pres[i].chk_imm)
        check($sformatf("imm[%0d]", i), out_instr[i].imm, pres[i].imm);
    end
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else if (byp) begin
      for (int unsigned i = take; i < nin; i++) sb.push_back(lanes[i]);
    end else begin
      for (int unsigned i = 0; i < take; i++) dropped = sb.pop_front();
      if (rdy) for (int unsigned i = 0; i < nin; i++) sb.push_back(lanes[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        z, e0, e1;
    logic [1:0]  v;
    logic        fl;
    int unsigned tk;
    z = mk_addi(5'd0, 5'd0, 12'd0, 64'd0);
    reset = 1'b1; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0; out_take = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();

    // reset state
    step(2'b00, z, z, 0, 1'b0);

    // addi x1,x0,5 and add x2,x1,x2, then consume both
    e0 = mk_addi(5'd1, 5'd0, 12'd5, 64'h8000_0000);
    e1 = mk_add(5'd2, 5'd1, 5'd2, 64'h8000_0004);
    step(2'b11, e0, e1, 0, 1'b0);
    step(2'b00, z, z, 2, 1'b0);
    step(2'b00, z, z, 0, 1'b0);

    // non-contiguous valid enqueues nothing
    step(2'b10, z, next_entry(), 0, 1'b0);
    step(2'b00, z, z, 0, 1'b0);

    // fill to full, try one more, then drain across the wrap
    for (int unsigned k = 0; k < 5; k++) step(2'b11, next_entry(), next_entry(), 0, 1'b0);
    for (int unsigned k = 0; k < 4; k++) step(2'b00, z, z, 2, 1'b0);
    step(2'b00, z, z, 0, 1'b0);

    // simultaneous enqueue and dequeue at count 3
    step(2'b11, next_entry(), next_entry(), 0, 1'b0);
    step(2'b01, next_entry(), z, 0, 1'b0);
    step(2'b11, next_entry(), next_entry(), 1, 1'b0);
    step(2'b00, z, z, 2, 1'b0);
    step(2'b00, z, z, 2, 1'b0);
    step(2'b00, z, z, 0, 1'b0);

    // illegal word, then flush at count 5 with traffic in the flush cycle
    step(2'b11, mk_bad(64'h9000_0000), next_entry(), 0, 1'b0);
    step(2'b11, mk_sw(5'd3, 5'd4, 12'h804, 64'h9000_0008), next_entry(), 0, 1'b0);
    step(2'b01, next_entry(), z, 0, 1'b0);
    step(2'b11, next_entry(), next_entry(), 2, 1'b1);
    step(2'b00, z, z, 0, 1'b0);

    // single lane into an empty queue, taken immediately when bypass exists
    step(2'b01, mk_addi(5'd7, 5'd2, 12'hFFF, 64'hA000_0000), z, BYP ? 1 : 0, 1'b0);
    step(2'b00, z, z, BYP ? 0 : 1, 1'b0);
    step(2'b00, z, z, 0, 1'b0);

    // random traffic with occasional flush
    for (int unsigned k = 0; k < 300; k++) begin
      v  = 2'($urandom);
      fl = ($urandom_range(0, 19) == 0);
      tk = $urandom_range(0, avail_of(v, fl));
      e0 = next_entry();
      e1 = next_entry();
      step(v, e0, e1, tk, fl);
    end
    while (sb.size() > 0) step(2'b00, z, z, avail_of(2'b00, 1'b0), 1'b0);
    step(2'b00, z, z, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
